// File: rtl/if_stage_pkg.sv
// Shared constants and payload types for the RV64 instruction-fetch stage.
// Consumers: if_stage, if_stage_out_buf.
package if_stage_pkg;

  localparam int BUS_64 = 64;
  localparam int BUS_32 = 32;

  localparam logic [BUS_64-1:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [BUS_32-1:0] INST_NOP = 32'h0000_0013;
  localparam logic [BUS_64-1:0] PC_STEP  = 64'd4;

  typedef struct packed {
    logic [BUS_64-1:0] pc;
    logic [BUS_32-1:0] inst;
  } fetch_pkt_t;

  function automatic logic [BUS_64-1:0] align_pc(input logic [BUS_64-1:0] pc);
    return pc & ~64'h3;
  endfunction

endpackage

// File: rtl/if_stage_out_buf.sv
// Single-entry valid/ready output register between fetch and decode.
// Flush beats load beats consume; a load in the same cycle as a consume refills the slot.
module if_stage_out_buf
  import if_stage_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  fetch_pkt_t i_load_pkt,
  input  logic       i_consume,
  input  logic       i_flush,
  output logic       o_valid,
  output logic       o_slot_free,
  output fetch_pkt_t o_pkt
);

  logic       r_valid;
  fetch_pkt_t r_pkt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_pkt   <= '{pc: '0, inst: INST_NOP};
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pkt   <= i_load_pkt;
    end else if (r_valid && i_consume) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid     = r_valid;
  assign o_pkt       = r_pkt;
  assign o_slot_free = !r_valid || i_consume;

endmodule

// File: rtl/if_stage.sv
// RV64 instruction-fetch stage: one outstanding imem request, redirect flush/kill.
// Optional misaligned-redirect trap enabled by defining IF_MISALIGN_TRAP_EN.
//   state  | meaning
//   S_REQ  | request pc when the output slot is free
//   S_WAIT | request accepted, waiting for rvalid (dropped if r_kill)
//   S_HALT | misaligned redirect seen; idle until an aligned redirect
module if_stage
  import if_stage_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic              o_imem_req,
  output logic [BUS_64-1:0] o_imem_addr,
  input  logic              i_imem_gnt,
  input  logic              i_imem_rvalid,
  input  logic [BUS_32-1:0] i_imem_rdata,
  input  logic              i_redirect_valid,
  input  logic [BUS_64-1:0] i_redirect_pc,
  input  logic              i_id_ready,
  output logic              o_inst_valid,
  output logic [BUS_32-1:0] o_inst,
  output logic [BUS_64-1:0] o_inst_pc,
  output logic              o_fetch_misalign
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2
  } state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [BUS_64-1:0] r_pc;
  logic [BUS_64-1:0] w_pc_nxt;
  logic              r_kill;
  logic              w_kill_nxt;
  logic              w_load;
  logic              w_flush;
  logic              w_slot_free;
  logic              w_req;
  logic              w_inflight;
  logic [BUS_64-1:0] w_redir_pc;
  fetch_pkt_t        w_load_pkt;
  fetch_pkt_t        w_out_pkt;

`ifdef IF_MISALIGN_TRAP_EN
  logic r_misalign;
  logic w_misalign_nxt;
  logic w_misaligned;

  assign w_misaligned = |i_redirect_pc[1:0];
  assign w_redir_pc   = i_redirect_pc;
`else
  assign w_redir_pc   = align_pc(i_redirect_pc);
`endif

  assign w_req      = (r_state == S_REQ) && w_slot_free;
  assign w_load_pkt = '{pc: r_pc, inst: i_imem_rdata};

  // A request is still owed a response after this cycle; a redirect now must kill it.
  assign w_inflight = ((r_state == S_WAIT) && !i_imem_rvalid) ||
                      ((r_state == S_REQ)  && w_req && i_imem_gnt) ||
                      ((r_state == S_HALT) && r_kill && !i_imem_rvalid);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_kill_nxt  = r_kill;
    w_load      = 1'b0;
    w_flush     = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
    w_misalign_nxt = r_misalign;
`endif

    case (r_state)
      S_REQ: begin
        if (w_req && i_imem_gnt) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (i_imem_rvalid) begin
          w_state_nxt = S_REQ;
          if (r_kill) begin
            w_kill_nxt = 1'b0;
          end else begin
            w_load   = 1'b1;
            w_pc_nxt = r_pc + PC_STEP;
          end
        end
      end
      S_HALT: begin
        if (i_imem_rvalid) w_kill_nxt = 1'b0;
      end
      default: w_state_nxt = S_REQ;
    endcase

    if (i_redirect_valid) begin
      w_flush  = 1'b1;
      w_load   = 1'b0;
      w_pc_nxt = w_redir_pc;
      if (w_inflight) begin
        w_kill_nxt  = 1'b1;
        w_state_nxt = S_WAIT;
      end else begin
        w_kill_nxt  = 1'b0;
        w_state_nxt = S_REQ;
      end
`ifdef IF_MISALIGN_TRAP_EN
      if (w_misaligned) begin
        w_misalign_nxt = 1'b1;
        w_state_nxt    = S_HALT;
      end else begin
        w_misalign_nxt = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_REQ;
      r_pc    <= RESET_PC;
      r_kill  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_kill  <= w_kill_nxt;
    end
  end

`ifdef IF_MISALIGN_TRAP_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_misalign <= 1'b0;
    else          r_misalign <= w_misalign_nxt;
  end
  assign o_fetch_misalign = r_misalign;
`else
  assign o_fetch_misalign = 1'b0;
`endif

  if_stage_out_buf u_out_buf (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_load      (w_load),
    .i_load_pkt  (w_load_pkt),
    .i_consume   (i_id_ready),
    .i_flush     (w_flush),
    .o_valid     (o_inst_valid),
    .o_slot_free (w_slot_free),
    .o_pkt       (w_out_pkt)
  );

  assign o_inst      = w_out_pkt.inst;
  assign o_inst_pc   = w_out_pkt.pc;
  assign o_imem_req  = w_req;
  assign o_imem_addr = r_pc;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, back-pressure, redirect kill/drop,
// delayed grant, misaligned redirect (both builds) and PC wrap.
module tb_if_stage;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        o_imem_req;
  logic [63:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        i_redirect_valid;
  logic [63:0] i_redirect_pc;
  logic        i_id_ready;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [63:0] o_inst_pc;
  logic        o_fetch_misalign;

  int n_vec = 0;
  int n_err = 0;

  if_stage dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .o_imem_req       (o_imem_req),
    .o_imem_addr      (o_imem_addr),
    .i_imem_gnt       (i_imem_gnt),
    .i_imem_rvalid    (i_imem_rvalid),
    .i_imem_rdata     (i_imem_rdata),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .i_id_ready       (i_id_ready),
    .o_inst_valid     (o_inst_valid),
    .o_inst           (o_inst),
    .o_inst_pc        (o_inst_pc),
    .o_fetch_misalign (o_fetch_misalign)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  initial begin
    i_rst_n          = 1'b0;
    i_imem_gnt       = 1'b0;
    i_imem_rvalid    = 1'b0;
    i_imem_rdata     = 32'h0;
    i_redirect_valid = 1'b0;
    i_redirect_pc    = 64'h0;
    i_id_ready       = 1'b0;
    repeat (2) @(negedge i_clk);

    chk("rst_inst_valid", o_inst_valid, 64'd0);
    chk("rst_inst", o_inst, 64'h0000_0013);
    chk("rst_inst_pc", o_inst_pc, 64'h0);
    chk("rst_misalign", o_fetch_misalign, 64'd0);

    i_rst_n = 1'b1;
    #1;
    chk("first_req", o_imem_req, 64'd1);
    chk("first_addr", o_imem_addr, 64'h8000_0000);

    // zero-wait memory: grant now, response next cycle
    i_imem_gnt = 1'b1;
    tick();
    chk("wait_no_req", o_imem_req, 64'd0);
    i_imem_gnt = 1'b0; i_imem_rvalid = 1'b1; i_imem_rdata = 32'h0010_0093;
    tick();
    i_imem_rvalid = 1'b0;
    chk("f1_valid", o_inst_valid, 64'd1);
    chk("f1_inst", o_inst, 64'h0010_0093);
    chk("f1_pc", o_inst_pc, 64'h8000_0000);
    chk("f1_next_addr", o_imem_addr, 64'h8000_0004);
    chk("f1_stall_req", o_imem_req, 64'd0);

    // decode stalls for five cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_req", o_imem_req, 64'd0);
      chk("stall_inst", o_inst, 64'h0010_0093);
    end
    i_id_ready = 1'b1;
    #1;
    chk("unstall_req", o_imem_req, 64'd1);
    chk("unstall_addr", o_imem_addr, 64'h8000_0004);
    i_imem_gnt = 1'b1;
    tick();
    chk("consumed", o_inst_valid, 64'd0);
    chk("f2_wait_req", o_imem_req, 64'd0);
    i_imem_gnt = 1'b0; i_imem_rvalid = 1'b1; i_imem_rdata = 32'h0020_0113;
    tick();
    i_imem_rvalid = 1'b0;
    chk("f2_inst", o_inst, 64'h0020_0113);
    chk("f2_pc", o_inst_pc, 64'h8000_0004);
    chk("f2_req", o_imem_req, 64'd1);
    chk("f2_addr", o_imem_addr, 64'h8000_0008);

    // redirect while the request for 0x8000_0008 is in flight
    i_imem_gnt = 1'b1;
    tick();
    i_imem_gnt = 1'b0; i_redirect_valid = 1'b1; i_redirect_pc = 64'h8000_0100;
    tick();
    i_redirect_valid = 1'b0;
    chk("kill_wait_req", o_imem_req, 64'd0);
    chk("kill_addr", o_imem_addr, 64'h8000_0100);
    chk("kill_valid", o_inst_valid, 64'd0);
    i_imem_rvalid = 1'b1; i_imem_rdata = 32'hDEAD_BEEF;
    tick();
    i_imem_rvalid = 1'b0;
    chk("drop_valid", o_inst_valid, 64'd0);
    chk("drop_req", o_imem_req, 64'd1);
    chk("drop_addr", o_imem_addr, 64'h8000_0100);
    i_imem_gnt = 1'b1;
    tick();
    i_imem_gnt = 1'b0; i_imem_rvalid = 1'b1; i_imem_rdata = 32'h0030_0193;
    tick();
    i_imem_rvalid = 1'b0;
    chk("f3_inst", o_inst, 64'h0030_0193);
    chk("f3_pc", o_inst_pc, 64'h8000_0100);
    chk("f3_addr", o_imem_addr, 64'h8000_0104);

    // redirect coincident with rvalid and id_ready
    i_imem_gnt = 1'b1;
    tick();
    i_imem_gnt = 1'b0; i_imem_rvalid = 1'b1; i_imem_rdata = 32'h0040_0213;
    i_redirect_valid = 1'b1; i_redirect_pc = 64'h8000_0300;
    tick();
    i_imem_rvalid = 1'b0; i_redirect_valid = 1'b0;
    chk("coin_valid", o_inst_valid, 64'd0);
    chk("coin_req", o_imem_req, 64'd1);
    chk("coin_addr", o_imem_addr, 64'h8000_0300);

    // grant withheld for three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_req", o_imem_req, 64'd1);
      chk("hold_addr", o_imem_addr, 64'h8000_0300);
    end
    i_imem_gnt = 1'b1;
    tick();
    i_imem_gnt = 1'b0; i_imem_rvalid = 1'b1; i_imem_rdata = 32'h0050_0293;
    tick();
    i_imem_rvalid = 1'b0;
    chk("f4_inst", o_inst, 64'h0050_0293);
    chk("f4_pc", o_inst_pc, 64'h8000_0300);
    chk("f4_addr", o_imem_addr, 64'h8000_0304);

    // misaligned redirect
    i_redirect_valid = 1'b1; i_redirect_pc = 64'h8000_0402;
    tick();
    i_redirect_valid = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
    chk("mis_flag", o_fetch_misalign, 64'd1);
    chk("mis_valid", o_inst_valid, 64'd0);
    chk("mis_req", o_imem_req, 64'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("halt_req", o_imem_req, 64'd0);
    end
    i_redirect_valid = 1'b1; i_redirect_pc = 64'h8000_0200;
    tick();
    i_redirect_valid = 1'b0;
    chk("mis_clear", o_fetch_misalign, 64'd0);
    chk("resume_req", o_imem_req, 64'd1);
    chk("resume_addr", o_imem_addr, 64'h8000_0200);
    i_imem_gnt = 1'b1;
    tick();
    i_imem_gnt = 1'b0; i_imem_rvalid = 1'b1; i_imem_rdata = 32'h0060_0313;
    tick();
    i_imem_rvalid = 1'b0;
    chk("f5_inst", o_inst, 64'h0060_0313);
    chk("f5_pc", o_inst_pc, 64'h8000_0200);
`else
    chk("mis_flag_off", o_fetch_misalign, 64'd0);
    chk("mis_valid", o_inst_valid, 64'd0);
    chk("mis_req", o_imem_req, 64'd1);
    chk("mis_addr_aligned", o_imem_addr, 64'h8000_0400);
    i_imem_gnt = 1'b1;
    tick();
    i_imem_gnt = 1'b0; i_imem_rvalid = 1'b1; i_imem_rdata = 32'h0060_0313;
    tick();
    i_imem_rvalid = 1'b0;
    chk("f5_inst", o_inst, 64'h0060_0313);
    chk("f5_pc", o_inst_pc, 64'h8000_0400);
`endif

    // redirect in the same cycle a request is granted
    i_imem_gnt = 1'b1; i_redirect_valid = 1'b1; i_redirect_pc = 64'h8000_0500;
    tick();
    i_imem_gnt = 1'b0; i_redirect_valid = 1'b0;
    chk("gkill_req", o_imem_req, 64'd0);
    chk("gkill_valid", o_inst_valid, 64'd0);
    chk("gkill_addr", o_imem_addr, 64'h8000_0500);
    i_imem_rvalid = 1'b1; i_imem_rdata = 32'hBAD0_0001;
    tick();
    i_imem_rvalid = 1'b0;
    chk("gdrop_valid", o_inst_valid, 64'd0);
    chk("gdrop_req", o_imem_req, 64'd1);
    chk("gdrop_addr", o_imem_addr, 64'h8000_0500);

    // 64-bit PC wrap
    i_redirect_valid = 1'b1; i_redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    i_redirect_valid = 1'b0;
    chk("wrap_addr", o_imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    i_imem_gnt = 1'b1;
    tick();
    i_imem_gnt = 1'b0; i_imem_rvalid = 1'b1; i_imem_rdata = 32'h0070_0393;
    tick();
    i_imem_rvalid = 1'b0;
    chk("wrap_inst", o_inst, 64'h0070_0393);
    chk("wrap_pc", o_inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_next", o_imem_addr, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
